// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: a WIDTH-bit operand pair is processed DIGIT bits per
// cycle, LSB digit first, through a DIGIT-bit ripple chain linked by a registered carry.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Digit datapath: the low DIGIT bits of the shifting operand registers.
  logic [DIGIT-1:0] dsum;
  logic             digit_cout;
  logic             digit_cmsb;
  logic             c;

  always_comb begin
    dsum       = '0;
    digit_cmsb = 1'b0;
    c          = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) digit_cmsb = c;
      dsum[i] = opa_q[i] ^ opb_q[i] ^ c;
      c       = (opa_q[i] & opb_q[i]) | (c & (opa_q[i] ^ opb_q[i]));
    end
    digit_cout = c;
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        opa_d                  = opa_q >> DIGIT;
        opb_d                  = opb_q >> DIGIT;
        res_d                  = res_q >> DIGIT;
        res_d[WIDTH-1 -: DIGIT] = dsum;
        carry_d                = digit_cout;
        cnt_d                  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          // Final digit carries the MSB, so its chain supplies both flags.
          sum_d   = res_d;
          cout_d  = digit_cout;
          ovf_d   = digit_cmsb ^ digit_cout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: 8-bit bit-serial instance with a scoreboard,
// plus 1-bit and 4-bit/2-digit instances swept exhaustively against an integer model.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start_s, sub_s, cin_s;
  logic [3:0] a_s, b_s;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_addsub #(.WIDTH(1), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_s), .sub(sub_s), .a(a_s[0:0]), .b(b_s[0:0]), .cin(cin_s),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

  serial_addsub #(.WIDTH(4), .DIGIT(2)) dut4 (
    .clk(clk), .rst(rst), .start(start_s), .sub(sub_s), .a(a_s), .b(b_s), .cin(cin_s),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

  int checks = 0;
  int errors = 0;

  // Expected {ovf, cout, sum} for each accepted 8-bit operation, oldest first.
  logic [9:0] exp_q[$];

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] sum;
    logic       cout, ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {cout,sum} = A + B' + (cin^sub); overflow from operand/result sign bits.
  function automatic logic [9:0] model(int w, logic [7:0] av, logic [7:0] bv, logic ci, logic sb);
    int mask, bp, full, s, co, sa, sbp, ss;
    mask = (1 << w) - 1;
    bp   = sb ? ((~int'(bv)) & mask) : (int'(bv) & mask);
    full = (int'(av) & mask) + bp + int'(ci ^ sb);
    s    = full & mask;
    co   = (full >> w) & 1;
    sa   = (int'(av) >> (w - 1)) & 1;
    sbp  = (bp >> (w - 1)) & 1;
    ss   = (s >> (w - 1)) & 1;
    return {((sa == sbp) && (ss != sa)) ? 1'b1 : 1'b0, co[0], s[7:0]};
  endfunction

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_done", 32'(done8), 32'd0);
      else                   check("sb_result", 32'({ovf8, cout8, sum8}), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_done8(output int busy_n);
    busy_n = 0;
    for (int t = 0; t < 40; t++) begin
      if (done8) break;
      if (busy8) busy_n++;
      @(negedge clk);
    end
    if (!done8) begin
      check("done8_timeout", 32'(done8), 32'd1);
      exp_q.delete();
    end
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb,
                      input logic [9:0] expv, output int busy_n);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = ci; sub8 = sb; start8 = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(busy_n);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         busy_n, cnt, t1, t2;
    logic [9:0] m1, m4;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start_s = 1'b0; sub_s = 1'b0; cin_s = 1'b0; a_s = '0; b_s = '0;
    repeat (2) @(negedge clk);
    check("reset_dut8", 32'({busy8, done8, ovf8, cout8, sum8}), 32'd0);
    check("reset_dut4", 32'({busy4, done4, ovf4, cout4, sum4}), 32'd0);
    rst = 1'b0;

    // Directed vectors: result, busy length and one-cycle done.
    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
           {vecs[i].ovf, vecs[i].cout, vecs[i].sum}, busy_n);
      check($sformatf("vec%0d_result", i), 32'({done8, ovf8, cout8, sum8}),
            32'({1'b1, vecs[i].ovf, vecs[i].cout, vecs[i].sum}));
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd8);
      @(negedge clk);
      check($sformatf("vec%0d_done_width", i), 32'(done8), 32'd0);
    end
    repeat (3) @(negedge clk);
    check("result_held", 32'({ovf8, cout8, sum8}), 32'({vecs[7].ovf, vecs[7].cout, vecs[7].sum}));

    // Random operands against the model.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      logic       rc, rs;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run8(ra, rb, rc, rs, model(8, ra, rb, rc, rs), busy_n);
    end

    // Second start during RUN is ignored; later input changes do not disturb the operation.
    @(negedge clk);
    a8 = 8'h21; b8 = 8'h14; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(model(8, 8'h21, 8'h14, 1'b0, 1'b0));
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    a8 = 8'h99; b8 = 8'h77; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hAB; b8 = 8'hCD; cin8 = 1'b1;
    wait_done8(busy_n);
    check("ignored_start_sum", 32'(sum8), 32'h35);
    cnt = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done8) cnt++;
    end
    check("ignored_start_no_extra_done", 32'(cnt), 32'd0);

    // start held through DONE: back-to-back operations, done pulses N+1 apart.
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(model(8, 8'h0F, 8'h01, 1'b0, 1'b0));
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h40;
    exp_q.push_back(model(8, 8'h40, 8'h40, 1'b0, 1'b0));
    t1 = -1; t2 = -1;
    for (int t = 0; t < 40 && t2 < 0; t++) begin
      if (done8) begin
        if (t1 < 0) t1 = t;
        else        t2 = t;
      end
      @(negedge clk);
      if (t1 >= 0) start8 = 1'b0;
    end
    start8 = 1'b0;
    check("b2b_done_spacing", 32'(t2 - t1), 32'd9);
    check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset at E3 of an operation: abandoned, outputs zeroed, no done.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(model(8, 8'h33, 8'h11, 1'b0, 1'b0));
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_reset_outputs", 32'({busy8, done8, ovf8, cout8, sum8}), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done8) cnt++;
    end
    check("mid_reset_no_done", 32'(cnt), 32'd0);
    run8(8'h33, 8'h11, 1'b1, 1'b1, model(8, 8'h33, 8'h11, 1'b1, 1'b1), busy_n);
    check("after_reset_busy_cycles", 32'(busy_n), 32'd8);

    // Exhaustive sweep: WIDTH=4/DIGIT=2 all 2^10 cases, WIDTH=1 all 16 cases.
    for (int v = 0; v < 1024; v++) begin
      @(negedge clk);
      {a_s, b_s, cin_s, sub_s} = v[9:0];
      start_s = 1'b1;
      m1 = model(1, {4'b0, a_s}, {4'b0, b_s}, cin_s, sub_s);
      m4 = model(4, {4'b0, a_s}, {4'b0, b_s}, cin_s, sub_s);
      @(negedge clk);
      start_s = 1'b0;
      check("small_busy", 32'({busy1, busy4}), 32'd3);
      @(negedge clk);
      if (a_s[3:1] == 3'd0 && b_s[3:1] == 3'd0)
        check("w1_result", 32'({done1, ovf1, cout1, sum1}), 32'({1'b1, m1[9], m1[8], m1[0]}));
      @(negedge clk);
      check("w4_result", 32'({done4, ovf4, cout4, sum4}), 32'({1'b1, m4[9], m4[8], m4[3:0]}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
